// File: rtl/idma_rd_2d_req_gen_if.sv
// Request/data handshake bundle between the 2D request generator and the sync iDMA read channel.
// master = request generator, slave = DMA read channel.
interface idma_rd_2d_req_gen_if #(
  parameter int AXI_ADDR_WID = 32
) ();
  logic                    rd_req;
  logic [AXI_ADDR_WID-1:0] rd_addr;
  logic [31:0]             rd_num;
  logic                    rd_addr_ready;
  logic                    rd_data_valid;
  logic                    rd_data_ready;

  modport master (
    output rd_req, rd_addr, rd_num,
    input  rd_addr_ready, rd_data_valid, rd_data_ready
  );

  modport slave (
    input  rd_req, rd_addr, rd_num,
    output rd_addr_ready, rd_data_valid, rd_data_ready
  );
endinterface

// File: rtl/idma_rd_2d_req_gen.sv
// 2D strided read-request generator: one DMA request per row, counts returned beats, flags completion.
// Optional IDMA_RD2D_STICKY_INTR_EN: done_intr latches until intr_clr instead of pulsing for one cycle.
module idma_rd_2d_req_gen #(
  parameter int AXI_ADDR_WID = 32,
  parameter int ROW_WID      = 16,
  parameter int BEAT_CNT_WID = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_start,
  input  logic [AXI_ADDR_WID-1:0] cfg_base_addr,
  input  logic [ROW_WID-1:0]      cfg_row_words,
  input  logic [AXI_ADDR_WID-1:0] cfg_row_stride,
  input  logic [ROW_WID-1:0]      cfg_row_num,
  input  logic                    intr_clr,
  output logic                    busy,
  output logic                    done_intr,
  output logic [BEAT_CNT_WID-1:0] beat_cnt,
  idma_rd_2d_req_gen_if.master    rd
);

  if (BEAT_CNT_WID < 2 * ROW_WID) begin : g_bad_cnt_wid
    $error("BEAT_CNT_WID must be at least 2*ROW_WID");
  end

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [ROW_WID-1:0]      row_num_q, row_idx_q;
  logic [AXI_ADDR_WID-1:0] stride_q;
  logic [BEAT_CNT_WID-1:0] total_q, total_calc;
  logic                    start_fire, req_fire, beat_fire, last_row, cnt_done;

  assign total_calc = BEAT_CNT_WID'(cfg_row_words) * BEAT_CNT_WID'(cfg_row_num);
  assign start_fire = (state_q == ST_IDLE) & cfg_start;
  assign req_fire   = rd.rd_req & rd.rd_addr_ready;
  // Beats count only while rows are outstanding; IDLE and DONE ignore the data bus.
  assign beat_fire  = rd.rd_data_valid & rd.rd_data_ready &
                      ((state_q == ST_ISSUE) | (state_q == ST_WAIT_DATA));
  assign last_row   = (row_idx_q == row_num_q - ROW_WID'(1));
  assign cnt_done   = (beat_cnt == total_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) state_d = (total_calc == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (req_fire && last_row) state_d = cnt_done ? ST_DONE : ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (cnt_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      rd.rd_req  <= 1'b0;
      rd.rd_addr <= '0;
      rd.rd_num  <= '0;
      beat_cnt   <= '0;
      row_num_q  <= '0;
      row_idx_q  <= '0;
      stride_q   <= '0;
      total_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != ST_IDLE);
      rd.rd_req <= (state_d == ST_ISSUE);
      if (start_fire) begin
        row_num_q  <= cfg_row_num;
        stride_q   <= cfg_row_stride;
        total_q    <= total_calc;
        row_idx_q  <= '0;
        rd.rd_addr <= cfg_base_addr;
        rd.rd_num  <= 32'(cfg_row_words);
        beat_cnt   <= '0;
      end else begin
        if (req_fire) begin
          row_idx_q  <= row_idx_q + ROW_WID'(1);
          // Address arithmetic wraps modulo 2^AXI_ADDR_WID by construction.
          rd.rd_addr <= rd.rd_addr + stride_q;
        end
        if (beat_fire) beat_cnt <= beat_cnt + BEAT_CNT_WID'(1);
      end
    end
  end

`ifdef IDMA_RD2D_STICKY_INTR_EN
  // Set on entry to DONE has priority over a simultaneous clear.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      done_intr <= 1'b0;
    end else if (state_d == ST_DONE) begin
      done_intr <= 1'b1;
    end else if (intr_clr) begin
      done_intr <= 1'b0;
    end
  end
`else
  logic unused_intr_clr;
  assign unused_intr_clr = intr_clr;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      done_intr <= 1'b0;
    end else begin
      done_intr <= (state_d == ST_DONE);
    end
  end
`endif

endmodule

// File: tb/tb_idma_rd_2d_req_gen.sv
// Directed self-checking bench for idma_rd_2d_req_gen; inputs driven and outputs sampled on negedge.
// Expected done_intr behaviour after DONE follows IDMA_RD2D_STICKY_INTR_EN.
module tb_idma_rd_2d_req_gen;

`ifdef IDMA_RD2D_STICKY_INTR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_row_words;
  logic [31:0] cfg_row_stride;
  logic [15:0] cfg_row_num;
  logic        intr_clr;
  logic        busy;
  logic        done_intr;
  logic [31:0] beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  idma_rd_2d_req_gen_if #(.AXI_ADDR_WID(32)) rd_if ();

  idma_rd_2d_req_gen #(
    .AXI_ADDR_WID(32),
    .ROW_WID     (16),
    .BEAT_CNT_WID(32)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_row_words (cfg_row_words),
    .cfg_row_stride(cfg_row_stride),
    .cfg_row_num   (cfg_row_num),
    .intr_clr      (intr_clr),
    .busy          (busy),
    .done_intr     (done_intr),
    .beat_cnt      (beat_cnt),
    .rd            (rd_if)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pulses cfg_start for one cycle, then scrambles cfg so only latched values matter.
  // Returns at the negedge of cycle N+1.
  task automatic start(input logic [31:0] base, input logic [15:0] words,
                       input logic [31:0] stride, input logic [15:0] rows);
    cfg_base_addr  = base;
    cfg_row_words  = words;
    cfg_row_stride = stride;
    cfg_row_num    = rows;
    cfg_start      = 1'b1;
    @(negedge aclk);
    cfg_start      = 1'b0;
    cfg_base_addr  = 32'hDEAD_BEEF;
    cfg_row_words  = 16'h7777;
    cfg_row_stride = 32'h0BAD_0000;
    cfg_row_num    = 16'h0009;
  endtask

  task automatic send_beats(input int n);
    rd_if.rd_data_valid = 1'b1;
    rd_if.rd_data_ready = 1'b1;
    for (int i = 0; i < n; i++) @(negedge aclk);
    rd_if.rd_data_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done_intr && i < budget) begin
      @(negedge aclk);
      i++;
    end
    check("done_timeout", done_intr, 1);
  endtask

  task automatic clear_intr();
    intr_clr = 1'b1;
    @(negedge aclk);
    intr_clr = 1'b0;
  endtask

  task automatic check_row(input string tag, input logic [31:0] addr, input logic [31:0] num);
    check({tag, "_req"},  rd_if.rd_req, 1);
    check({tag, "_addr"}, rd_if.rd_addr, addr);
    check({tag, "_num"},  rd_if.rd_num, num);
  endtask

  initial begin
    areset = 1'b1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_row_words = '0;
    cfg_row_stride = '0;
    cfg_row_num = '0;
    intr_clr = 1'b0;
    rd_if.rd_addr_ready = 1'b1;
    rd_if.rd_data_valid = 1'b0;
    rd_if.rd_data_ready = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_req", rd_if.rd_req, 0);
    check("rst_addr", rd_if.rd_addr, 0);
    check("rst_num", rd_if.rd_num, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_intr, 0);
    check("rst_beats", beat_cnt, 0);
    areset = 1'b0;
    @(negedge aclk);

    // Back-to-back rows with ready tied high, then 12 beats.
    start(32'h1000_0000, 16'd4, 32'h400, 16'd3);
    check("t1_busy", busy, 1);
    check_row("t1_r0", 32'h1000_0000, 4);
    @(negedge aclk);
    check_row("t1_r1", 32'h1000_0400, 4);
    @(negedge aclk);
    check_row("t1_r2", 32'h1000_0800, 4);
    @(negedge aclk);
    check("t1_req_drop", rd_if.rd_req, 0);
    check("t1_beats0", beat_cnt, 0);
    send_beats(12);
    check("t1_beats12", beat_cnt, 12);
    check("t1_not_done_yet", done_intr, 0);
    @(negedge aclk);
    check("t1_done", done_intr, 1);
    check("t1_busy_in_done", busy, 1);
    @(negedge aclk);
    check("t1_busy_off", busy, 0);
    check("t1_intr_after", done_intr, STICKY);
    repeat (2) @(negedge aclk);
    check("t1_intr_hold", done_intr, STICKY);

    // Backpressure on row 1; a new start must not clear a sticky interrupt.
    start(32'h1000_0000, 16'd4, 32'h400, 16'd3);
    check("t2_intr_on_start", done_intr, STICKY);
    check_row("t2_r0", 32'h1000_0000, 4);
    intr_clr = 1'b1;
    @(negedge aclk);
    intr_clr = 1'b0;
    check("t2_intr_cleared", done_intr, 0);
    check_row("t2_r1", 32'h1000_0400, 4);
    rd_if.rd_addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_row("t2_r1_hold", 32'h1000_0400, 4);
    end
    rd_if.rd_addr_ready = 1'b1;
    @(negedge aclk);
    check_row("t2_r2", 32'h1000_0800, 4);
    @(negedge aclk);
    check("t2_req_drop", rd_if.rd_req, 0);
    send_beats(12);
    wait_done(5);
    check("t2_beats", beat_cnt, 12);
    @(negedge aclk);
    clear_intr();

    // Address wrap, completion only at exact total.
    start(32'hFFFF_FC00, 16'd2, 32'h400, 16'd2);
    check_row("t3_r0", 32'hFFFF_FC00, 2);
    @(negedge aclk);
    check_row("t3_r1_wrap", 32'h0000_0000, 2);
    @(negedge aclk);
    check("t3_req_drop", rd_if.rd_req, 0);
    send_beats(3);
    check("t3_beats3", beat_cnt, 3);
    @(negedge aclk);
    check("t3_early_done", done_intr, 0);
    check("t3_early_busy", busy, 1);
    send_beats(1);
    wait_done(5);
    check("t3_beats", beat_cnt, 4);
    @(negedge aclk);
    clear_intr();

    // Zero-size descriptors; intr_clr held across the set cycle (set wins).
    intr_clr = 1'b1;
    start(32'h0000_1000, 16'd5, 32'h40, 16'd0);
    check("t4a_done", done_intr, 1);
    check("t4a_req", rd_if.rd_req, 0);
    check("t4a_beats", beat_cnt, 0);
    @(negedge aclk);
    intr_clr = 1'b0;
    check("t4a_busy_off", busy, 0);
    check("t4a_intr_off", done_intr, 0);
    start(32'h0000_2000, 16'd0, 32'h40, 16'd3);
    check("t4b_done", done_intr, 1);
    check("t4b_req", rd_if.rd_req, 0);
    @(negedge aclk);
    clear_intr();

    // Beats interleaved with issue, second start while busy, start and beats in DONE.
    start(32'h0000_2000, 16'd3, 32'h100, 16'd2);
    check_row("t5_r0", 32'h0000_2000, 3);
    rd_if.rd_data_valid = 1'b1;
    rd_if.rd_data_ready = 1'b1;
    cfg_base_addr = 32'hDEAD_0000;
    cfg_row_num   = 16'd0;
    cfg_start     = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    check_row("t5_r1", 32'h0000_2100, 3);
    check("t5_beats1", beat_cnt, 1);
    @(negedge aclk);
    check("t5_req_drop", rd_if.rd_req, 0);
    check("t5_beats2", beat_cnt, 2);
    repeat (3) @(negedge aclk);
    rd_if.rd_data_valid = 1'b0;
    check("t5_beats5", beat_cnt, 5);
    check("t5_not_done", done_intr, 0);
    check("t5_busy", busy, 1);
    send_beats(1);
    check("t5_beats6", beat_cnt, 6);
    @(negedge aclk);
    check("t5_done", done_intr, 1);
    cfg_base_addr = 32'h0000_3000;
    cfg_row_words = 16'd1;
    cfg_row_num   = 16'd1;
    cfg_start     = 1'b1;
    rd_if.rd_data_valid = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    check("t5_start_in_done_busy", busy, 0);
    check("t5_start_in_done_req", rd_if.rd_req, 0);
    check("t5_beats_after_done", beat_cnt, 6);
    repeat (2) @(negedge aclk);
    rd_if.rd_data_valid = 1'b0;
    check("t5_idle_beats", beat_cnt, 6);

    // Asynchronous reset mid-WAIT_DATA, taken between clock edges.
    start(32'h0000_4000, 16'd4, 32'h80, 16'd2);
    @(negedge aclk);
    @(negedge aclk);
    send_beats(5);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_beats", beat_cnt, 5);
    #2 areset = 1'b1;
    #1;
    check("t6_rst_req", rd_if.rd_req, 0);
    check("t6_rst_addr", rd_if.rd_addr, 0);
    check("t6_rst_num", rd_if.rd_num, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done_intr, 0);
    check("t6_rst_beats", beat_cnt, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("t6_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
